ysyx_24090003_ifu: RTL and testbench

YSYX_24090003_IFU -- requirements
Module: ysyx_24090003_IFU

---
 rtl/ysyx_24090003_pkg.sv | 16 +
 rtl/ysyx_24090003_ifu.sv | 96 +++++++++
 tb/tb_ysyx_24090003_ifu.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24090003_pkg.sv
// Shared definitions for the ysyx_24090003 instruction fetch unit:
// datapath width, default reset PC and the fetch FSM state encoding.
package ysyx_24090003_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT,
    S_NPC
  } ifu_state_e;

endpackage

// File: rtl/ysyx_24090003_ifu.sv
// Instruction fetch unit: one outstanding fetch, REQ -> WAIT -> OUT -> NPC loop.
// Misaligned next-PCs bypass memory and deliver a faulting null instruction.
module ysyx_24090003_ifu
  import ysyx_24090003_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            npc_valid,
  input  logic [XLEN-1:0] npc
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            fault_q, fault_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    fault_d        = fault_q;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;

    unique case (state_q)
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          inst_d    = imem_resp_err ? '0 : imem_resp_data;
          fault_d   = imem_resp_err;
          inst_pc_d = pc_q;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        inst_valid = 1'b1;
        if (inst_ready) state_d = S_NPC;
      end
      S_NPC: begin
        if (npc_valid) begin
          pc_d = npc;
          // A misaligned target never reaches memory; it is reported as a fault.
          if (npc[1:0] == 2'b00) begin
            state_d = S_REQ;
          end else begin
            inst_d    = '0;
            fault_d   = 1'b1;
            inst_pc_d = npc;
            state_d   = S_OUT;
          end
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign imem_req_addr = pc_q;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_fault    = fault_q;

endmodule

// File: tb/tb_ysyx_24090003_ifu.sv
// Bench for ysyx_24090003_ifu: directed vector table, latency sequence,
// and randomized traffic against a transaction-level reference model.
module tb_ysyx_24090003_ifu;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_req_ready, imem_resp_valid, imem_resp_err, inst_ready, npc_valid;
  logic [31:0] imem_resp_data, npc;
  logic        imem_req_valid, inst_valid, inst_fault;
  logic [31:0] imem_req_addr, inst, inst_pc;

  int checks = 0;
  int errors = 0;

  ysyx_24090003_ifu #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_fault(inst_fault),
    .npc_valid(npc_valid),
    .npc(npc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, rdy, rv;
    logic [31:0] rdata;
    logic        rerr, irdy, nv;
    logic [31:0] npc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst, e_ipc;
    logic        e_f;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rdy, input logic rv,
                              input logic [31:0] rdata, input logic rerr,
                              input logic irdy, input logic nv, input logic [31:0] n,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_iv, input logic [31:0] e_inst,
                              input logic [31:0] e_ipc, input logic e_f);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.rerr = rerr;
    v.irdy = irdy; v.nv = nv; v.npc = n;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_f = e_f;
    return v;
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        f;
  } out_t;

  out_t        oq[$];
  logic [31:0] m_pc;
  logic        m_outstanding, m_awaiting, exp_req, exp_iv;
  vec_t        tbl[$];
  int          cyc;
  logic        seen;

  task automatic drive_idle();
    rst = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    imem_resp_err = 1'b0; inst_ready = 1'b0; npc_valid = 1'b0; npc = '0;
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    @(negedge clk);

    // rows: inputs applied for one cycle, expected outputs after the edge
    tbl.push_back(mk(1,0,0,32'h0,0,0,0,32'h0,            1,RPC,0,32'h0,RPC-RPC,0));
    tbl.push_back(mk(0,0,1,32'hDEAD_BEEF,0,0,0,32'h0,    1,RPC,0,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,1,32'h0000_1234,    1,RPC,0,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,0,32'h0,            1,RPC,0,32'h0,32'h0,0));
    tbl.push_back(mk(0,1,0,32'h0,0,0,0,32'h0,            0,RPC,0,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,1,32'h0010_0093,0,1,0,32'h0,    0,RPC,1,32'h0010_0093,RPC,0));
    tbl.push_back(mk(0,0,1,32'h1111_1111,0,0,1,32'h8000_0040, 0,RPC,1,32'h0010_0093,RPC,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,1,32'h8000_0044,    0,RPC,1,32'h0010_0093,RPC,0));
    tbl.push_back(mk(0,0,0,32'h0,0,1,0,32'h0,            0,RPC,0,32'h0010_0093,RPC,0));
    tbl.push_back(mk(0,1,1,32'h2222_2222,0,0,0,32'h0,    0,RPC,0,32'h0010_0093,RPC,0));
    tbl.push_back(mk(0,0,0,32'h0,0,0,1,32'h8000_0010,    1,32'h8000_0010,0,32'h0010_0093,RPC,0));
    tbl.push_back(mk(0,1,0,32'h0,0,0,0,32'h0,            0,32'h8000_0010,0,32'h0010_0093,RPC,0));
    tbl.push_back(mk(0,0,1,32'hFFFF_FFFF,1,0,0,32'h0,    0,32'h8000_0010,1,32'h0,32'h8000_0010,1));
    tbl.push_back(mk(0,0,0,32'h0,0,1,0,32'h0,            0,32'h8000_0010,0,32'h0,32'h8000_0010,1));
    tbl.push_back(mk(0,0,0,32'h0,0,0,1,32'h8000_0012,    0,32'h8000_0012,1,32'h0,32'h8000_0012,1));
    tbl.push_back(mk(0,0,0,32'h0,0,1,0,32'h0,            0,32'h8000_0012,0,32'h0,32'h8000_0012,1));
    tbl.push_back(mk(0,0,0,32'h0,0,0,1,32'h8000_0020,    1,32'h8000_0020,0,32'h0,32'h8000_0012,1));
    tbl.push_back(mk(0,1,0,32'h0,0,0,0,32'h0,            0,32'h8000_0020,0,32'h0,32'h8000_0012,1));
    tbl.push_back(mk(1,0,1,32'h3333_3333,0,1,1,32'h0,    1,RPC,0,32'h0,32'h0,0));
    tbl.push_back(mk(0,1,1,32'h4444_4444,0,0,0,32'h0,    0,RPC,0,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,1,32'h1234_5678,0,0,0,32'h0,    0,RPC,1,32'h1234_5678,RPC,0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; imem_req_ready = tbl[i].rdy; imem_resp_valid = tbl[i].rv;
      imem_resp_data = tbl[i].rdata; imem_resp_err = tbl[i].rerr;
      inst_ready = tbl[i].irdy; npc_valid = tbl[i].nv; npc = tbl[i].npc;
      @(negedge clk);
      chk($sformatf("vec%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].e_req});
      chk($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_inst_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].e_iv});
      chk($sformatf("vec%0d_inst", i), inst, tbl[i].e_inst);
      chk($sformatf("vec%0d_inst_pc", i), inst_pc, tbl[i].e_ipc);
      chk($sformatf("vec%0d_inst_fault", i), {31'b0, inst_fault}, {31'b0, tbl[i].e_f});
    end

    // Latency from reset and the minimum fetch loop
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("seq_req_after_reset", {31'b0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      imem_req_ready = 1'b0;
      if (inst_valid) seen = 1'b1;
      else begin
        imem_resp_valid = (cyc == 2);
        imem_resp_data = 32'h0010_0093;
      end
    end
    imem_resp_valid = 1'b0;
    chk("seq_latency_cycle", cyc, 32'd3);
    chk("seq_inst", inst, 32'h0010_0093);
    chk("seq_inst_pc", inst_pc, RPC);
    chk("seq_inst_fault", {31'b0, inst_fault}, 32'd0);
    @(negedge clk);
    chk("seq_npc_no_valid", {31'b0, inst_valid}, 32'd0);
    chk("seq_npc_no_req", {31'b0, imem_req_valid}, 32'd0);
    inst_ready = 1'b0;
    npc_valid = 1'b1;
    npc = 32'h8000_0010;
    @(negedge clk);
    npc_valid = 1'b0;
    chk("seq_loop_req", {31'b0, imem_req_valid}, 32'd1);
    chk("seq_loop_addr", imem_req_addr, 32'h8000_0010);

    // Randomized traffic against a transaction-level model
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_pc = RPC; m_outstanding = 1'b0; m_awaiting = 1'b0; oq.delete();
    for (int n = 0; n < 3000; n++) begin
      exp_req = !m_outstanding && (oq.size() == 0) && !m_awaiting;
      exp_iv  = (oq.size() != 0);
      chk("rand_req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
      if (exp_req) chk("rand_req_addr", imem_req_addr, m_pc);
      chk("rand_inst_valid", {31'b0, inst_valid}, {31'b0, exp_iv});
      if (exp_iv) begin
        chk("rand_inst", inst, oq[0].inst);
        chk("rand_inst_pc", inst_pc, oq[0].pc);
        chk("rand_inst_fault", {31'b0, inst_fault}, {31'b0, oq[0].f});
      end
      chk("rand_exclusive", {31'b0, imem_req_valid & inst_valid}, 32'd0);

      rst             = ($urandom_range(0, 199) == 0);
      imem_req_ready  = ($urandom_range(0, 2) != 0);
      imem_resp_valid = $urandom_range(0, 1) == 1;
      imem_resp_data  = $urandom;
      imem_resp_err   = ($urandom_range(0, 7) == 0);
      inst_ready      = $urandom_range(0, 1) == 1;
      npc_valid       = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) npc = ($urandom & 32'hFFFF_FFFC) | $urandom_range(1, 3);
      else npc = $urandom & 32'hFFFF_FFFC;

      if (rst) begin
        m_pc = RPC; m_outstanding = 1'b0; m_awaiting = 1'b0; oq.delete();
      end else if (exp_req) begin
        if (imem_req_ready) m_outstanding = 1'b1;
      end else if (m_outstanding) begin
        if (imem_resp_valid) begin
          m_outstanding = 1'b0;
          oq.push_back('{imem_resp_err ? 32'h0 : imem_resp_data, m_pc, imem_resp_err});
        end
      end else if (exp_iv) begin
        if (inst_ready) begin
          void'(oq.pop_front());
          m_awaiting = 1'b1;
        end
      end else if (m_awaiting && npc_valid) begin
        m_pc = npc;
        m_awaiting = 1'b0;
        if (npc[1:0] != 2'b00) oq.push_back('{32'h0, npc, 1'b1});
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
